// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pll_reset_pkg
// Purpose  : Shared types and constants for the PLL reset sequencer.
//            Holds the sequencer state encoding, the lock-loss counter width
//            and a small helper used to size the shared counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package pll_reset_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK   = 2'd0,
      STABILIZE   = 2'd1,
      RELEASE_SYS = 2'd2,
      RUN         = 2'd3
   } state_t;

   localparam int LOCK_LOSS_COUNT_WIDTH = 8;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pll_reset_sequencer_if
// Purpose  : Groups the PLL lock input and the sequenced reset outputs.
//            slave  : sequencer side (consumes pll_locked, drives resets)
//            master : PLL / environment side
// Signals  : pll_locked      - raw PLL lock, asynchronous to clk
//            sys_reset       - active-high reset for video/peripheral fabric
//            cpu_reset       - active-high reset for the CPU
//            ready           - high once both resets are released
//            lock_loss_count - saturating lock-loss count (LOCK_LOSS_COUNT_EN)
// Macro    : LOCK_LOSS_COUNT_EN adds lock_loss_count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface pll_reset_sequencer_if;
   import pll_reset_pkg::*;

   logic pll_locked;
   logic sys_reset;
   logic cpu_reset;
   logic ready;
`ifdef LOCK_LOSS_COUNT_EN
   logic [LOCK_LOSS_COUNT_WIDTH-1:0] lock_loss_count;
`endif

`ifdef LOCK_LOSS_COUNT_EN
   modport slave  (input  pll_locked, output sys_reset, output cpu_reset,
                   output ready, output lock_loss_count);
   modport master (output pll_locked, input  sys_reset, input  cpu_reset,
                   input  ready, input  lock_loss_count);
`else
   modport slave  (input  pll_locked, output sys_reset, output cpu_reset,
                   output ready);
   modport master (output pll_locked, input  sys_reset, input  cpu_reset,
                   input  ready);
`endif

endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer_lock_synchronizer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lock_synchronizer
// Purpose  : SYNC_STAGES-deep flop chain bringing an asynchronous level
//            signal into the clk domain, with a synchronous clear.
// Ports    : clk   - destination clock
//            clr_i - synchronous active-high clear of every stage
//            d_i   - asynchronous level input
//            q_o   - synchronised output (last stage)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module lock_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic clr_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pll_reset_sequencer
// Purpose  : Waits for the PLL lock to be stable for STABLE_CYCLES, then
//            releases sys_reset, and STAGGER_CYCLES later cpu_reset/ready.
//            Any loss of the synchronised lock reasserts all resets at once.
// Ports    : clk   - system clock
//            reset - synchronous active-high reset
//            bus   - pll_reset_sequencer_if.slave (pll_locked in; sys_reset,
//                    cpu_reset, ready, optional lock_loss_count out)
// Macro    : LOCK_LOSS_COUNT_EN enables the saturating lock-loss counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   pll_reset_sequencer_if.slave  bus
);

   localparam int CNT_W = $clog2(max2(STABLE_CYCLES, STAGGER_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

   logic             locked_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sys_reset_q, sys_reset_d;
   logic             cpu_reset_q, cpu_reset_d;
   logic             ready_q, ready_d;
   logic             lock_loss;

   lock_synchronizer #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clk),
      .clr_i (reset),
      .d_i   (bus.pll_locked),
      .q_o   (locked_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         sys_reset_q <= 1'b1;
         cpu_reset_q <= 1'b1;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sys_reset_q <= sys_reset_d;
         cpu_reset_q <= cpu_reset_d;
         ready_q     <= ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sys_reset_d = sys_reset_q;
      cpu_reset_d = cpu_reset_q;
      ready_d     = ready_q;
      lock_loss   = 1'b0;

      case (state_q)
         WAIT_LOCK: begin
            cnt_d       = '0;
            sys_reset_d = 1'b1;
            cpu_reset_d = 1'b1;
            ready_d     = 1'b0;
            if (locked_s) begin
               state_d = STABILIZE;
            end
         end
         STABILIZE: begin
            if (!locked_s) begin
               lock_loss = 1'b1;
            end else if (cnt_q == STABLE_LAST) begin
               state_d     = RELEASE_SYS;
               cnt_d       = '0;
               sys_reset_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE_SYS: begin
            if (!locked_s) begin
               lock_loss = 1'b1;
            end else if (cnt_q == STAGGER_LAST) begin
               state_d     = RUN;
               cnt_d       = '0;
               cpu_reset_d = 1'b0;
               ready_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!locked_s) begin
               lock_loss = 1'b1;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase

      // Lock loss overrides any completion decided above in the same cycle.
      if (lock_loss) begin
         state_d     = WAIT_LOCK;
         cnt_d       = '0;
         sys_reset_d = 1'b1;
         cpu_reset_d = 1'b1;
         ready_d     = 1'b0;
      end
   end

   assign bus.sys_reset = sys_reset_q;
   assign bus.cpu_reset = cpu_reset_q;
   assign bus.ready     = ready_q;

`ifdef LOCK_LOSS_COUNT_EN
   logic [LOCK_LOSS_COUNT_WIDTH-1:0] llc_q, llc_d;

   always_comb begin
      llc_d = llc_q;
      if (lock_loss && (llc_q != {LOCK_LOSS_COUNT_WIDTH{1'b1}})) begin
         llc_d = llc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         llc_q <= '0;
      end else begin
         llc_q <= llc_d;
      end
   end

   assign bus.lock_loss_count = llc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pll_reset_sequencer
// Purpose  : Self-checking bench for pll_reset_sequencer. A run-length model
//            of the synchronised lock predicts every cycle's outputs; a
//            monitor compares them on the falling edge.
// Macro    : LOCK_LOSS_COUNT_EN also checks lock_loss_count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   localparam int SYNC    = 2;
   localparam int STABLE  = 8;
   localparam int STAGGER = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pll_reset_sequencer_if bus ();

   pll_reset_sequencer #(
      .SYNC_STAGES    (SYNC),
      .STABLE_CYCLES  (STABLE),
      .STAGGER_CYCLES (STAGGER)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Expected vector: {sys_reset, cpu_reset, ready, lock_loss_count[7:0]}
   logic [10:0] exp_q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   // Model state: delay line for the synchroniser, consecutive-lock run
   // length seen by the sequencer, and the lock-loss count.
   bit dl[SYNC];
   int run = 0;
   int llc = 0;

   task automatic model_edge(input bit r, input bit p);
      logic [10:0] e;
      bit ls;
      if (r) begin
         for (int i = 0; i < SYNC; i++) dl[i] = 1'b0;
         run = 0;
         llc = 0;
      end else begin
         ls = dl[SYNC-1];
         if (ls) begin
            if (run < 100000) run++;
         end else begin
            if (run > 0 && llc < 255) llc++;
            run = 0;
         end
         for (int i = SYNC-1; i > 0; i--) dl[i] = dl[i-1];
         dl[0] = p;
      end
      // First locked cycle enters stabilisation; STABLE more complete it.
      e[10]  = !(run >= STABLE + 1);
      e[9]   = !(run >= STABLE + STAGGER + 1);
      e[8]   = (run >= STABLE + STAGGER + 1);
      e[7:0] = 8'(llc);
      exp_q.push_back(e);
   endtask

   task automatic step(input bit r, input bit p);
      #1;
      reset          = r;
      bus.pll_locked = p;
      @(posedge clk);
      model_edge(r, p);
   endtask

   task automatic hold(input bit r, input bit p, input int n);
      for (int i = 0; i < n; i++) step(r, p);
   endtask

   // Monitor: one expected entry per clock edge, checked mid-cycle.
   initial begin
      logic [10:0] e, a;
      forever begin
         @(negedge clk);
         cyc++;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef LOCK_LOSS_COUNT_EN
            a = {bus.sys_reset, bus.cpu_reset, bus.ready, bus.lock_loss_count};
`else
            a = {bus.sys_reset, bus.cpu_reset, bus.ready, e[7:0]};
`endif
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL outputs cyc=%0d got sys/cpu/rdy/llc=%b/%b/%b/%0d want %b/%b/%b/%0d",
                        cyc, a[10], a[9], a[8], a[7:0], e[10], e[9], e[8], e[7:0]);
            end
            total++;
            if ((bus.ready !== ~bus.cpu_reset) ||
                (bus.cpu_reset === 1'b0 && bus.sys_reset !== 1'b0)) begin
               bad++;
               $display("FAIL ordering cyc=%0d got sys=%b cpu=%b rdy=%b want rdy=~cpu and cpu=0 -> sys=0",
                        cyc, bus.sys_reset, bus.cpu_reset, bus.ready);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit p;
      reset          = 1'b1;
      bus.pll_locked = 1'b1;

      // Reset held with lock high: all resets stay asserted.
      hold(1, 1, 3);

      // Clean lock: sys release at E10, cpu/ready at E14, then stable.
      hold(0, 0, 3);
      hold(0, 1, 25);

      // Restart, then a one-cycle drop at E5 restarts the window.
      hold(1, 0, 2);
      hold(0, 0, 2);
      hold(0, 1, 5);
      hold(0, 0, 1);
      hold(0, 1, 20);

      // Lock lost in RUN for 3 cycles, then full sequence again.
      hold(0, 0, 3);
      hold(0, 1, 20);

      // Reset while in RELEASE_SYS, then full-latency restart.
      hold(1, 0, 1);
      hold(0, 1, 12);
      hold(1, 1, 1);
      hold(0, 1, 20);

      // Randomised bursts of lock with short drops and occasional resets.
      for (int k = 0; k < 40; k++) begin
         hold(0, 1, $urandom_range(1, 25));
         hold(0, 0, $urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) hold(1, $urandom_range(0, 1) != 0, 1);
      end
      for (int k = 0; k < 200; k++) begin
         p = ($urandom_range(0, 7) != 0);
         step($urandom_range(0, 99) == 0, p);
      end

      // 260 lock losses from RUN: counter saturates, then reset clears it.
      hold(1, 0, 1);
      for (int k = 0; k < 260; k++) begin
         hold(0, 1, 15);
         hold(0, 0, 1);
      end
      hold(0, 1, 3);
      hold(1, 1, 2);
      hold(0, 1, 5);

      @(negedge clk);
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Downstream consumer of the ECP5 PLL lock output, clocked by the 33.75 MHz system clock (CLKOS2).
- Synchronises the asynchronous PLL lock signal and requires it to stay high for a programmable interval.
- Then releases resets in a staggered order: system/video fabric first, CPU second.
- Any lock loss reasserts all resets immediately and restarts the sequence.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on pll_locked (legal: >=2)
STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before sys_reset release (legal: >=1)
STAGGER_CYCLES, 16, cycles between sys_reset release and cpu_reset release (legal: >=1)

Ports:
clk  input  1  system clock (33.75 MHz PLL output)
reset  input  1  synchronous active-high reset; forces sequencer to initial state
pll_locked  input  1  raw PLL LOCK, asynchronous to clk
sys_reset  output  1  active-high reset for video/peripheral logic, registered
cpu_reset  output  1  active-high reset for CPU, registered
ready  output  1  high when both resets are released
lock_loss_count  output  8  lock-loss event count (present only with LOCK_LOSS_COUNT_EN)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = WAIT_LOCK
  - sys_reset = 1, cpu_reset = 1, ready = 0
  - counter = 0
  - all synchroniser flops = 0
  - lock_loss_count = 0
- Synchroniser:
  - locked_s is the output of the SYNC_STAGES-deep flop chain fed by pll_locked.
  - The chain is cleared by reset.
- Counter: a single shared counter, width $clog2(max(STABLE_CYCLES, STAGGER_CYCLES)) + 1, unsigned, never wraps.
- WAIT_LOCK:
  - counter held at 0.
  - locked_s = 1 -> STABILIZE.
- STABILIZE:
  - counter increments each cycle.
  - locked_s = 0 -> WAIT_LOCK.
  - counter == STABLE_CYCLES-1 with locked_s = 1 -> RELEASE_SYS; counter cleared; sys_reset goes 0 on the same edge.
- RELEASE_SYS:
  - sys_reset = 0.
  - counter increments.
  - counter == STAGGER_CYCLES-1 -> RUN; cpu_reset and ready go to 0 and 1 respectively on the same edge.
- RUN:
  - all resets released, ready = 1.
  - Holds until lock is lost.
- Lock loss: locked_s = 0 in STABILIZE, RELEASE_SYS or RUN:
  - Next edge: state = WAIT_LOCK, counter = 0, sys_reset = 1, cpu_reset = 1, ready = 0.
  - This takes priority over any completion in the same cycle.
- Latency, with pll_locked held high from edge E0 (first edge sampling it high):
  - sys_reset falls at edge E0 + SYNC_STAGES + STABLE_CYCLES.
  - cpu_reset falls and ready rises STAGGER_CYCLES edges later.
- Lock glitches: any glitch shorter than STABLE_CYCLES that is seen at locked_s restarts the stability window from zero.
- Mid-operation reset: reset asserted in any state returns every register to its reset value on that edge, irrespective of pll_locked.
- Output ordering invariant: cpu_reset = 0 implies sys_reset = 0; ready == ~cpu_reset at all times.

Optional Feature:
LOCK_LOSS_COUNT_EN
- With the macro:
  - lock_loss_count port exists.
  - Increments by 1 on each lock-loss transition into WAIT_LOCK from STABILIZE, RELEASE_SYS or RUN; saturates at 255.
  - Not incremented by reset or while staying in WAIT_LOCK.
  - Cleared by reset.
- Without the macro: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pll_reset_pkg holds:
  - typedef enum state_t {WAIT_LOCK, STABILIZE, RELEASE_SYS, RUN}, 2-bit encoding
  - localparam LOCK_LOSS_COUNT_WIDTH = 8
- One sub-module, lock_synchronizer:
  - parameterised SYNC_STAGES flop chain with synchronous clear.
  - Reusable for other cross-domain level signals.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=8, STAGGER_CYCLES=4 unless noted.
1. Reset held 3 cycles, pll_locked = 1 -> sys_reset = 1, cpu_reset = 1, ready = 0 throughout reset.
2. pll_locked rises and is held from E0 -> sys_reset = 0 at E10; cpu_reset = 0 and ready = 1 at E14; outputs stable afterwards.
3. pll_locked drops for 1 cycle at E5, held otherwise:
   - sys_reset stays 1, window restarts.
   - release occurs 10 edges after the first edge sampling pll_locked high again.
4. In RUN, pll_locked drops for 3 cycles:
   - sys_reset = 1, cpu_reset = 1, ready = 0 two edges after the drop (synchroniser plus one).
   - full sequence repeats after lock returns.
   - with LOCK_LOSS_COUNT_EN, lock_loss_count = 1.
5. Reset asserted in RELEASE_SYS -> next edge sys_reset = 1, state WAIT_LOCK; sequence restarts from the synchroniser with full latency.
6. LOCK_LOSS_COUNT_EN build, 260 forced lock losses from RUN -> lock_loss_count = 255 (saturated); reset -> 0.
